// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivCtlIdle = 2'd0,
    DivCtlWait = 2'd1,
    DivCtlDone = 2'd2,
    DivCtlCool = 2'd3
  } div_ctl_state_e;

  localparam logic        DivStart       = 1'b1;
  localparam logic        DivStop        = 1'b0;
  localparam logic        DivResultReady = 1'b1;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage controller for the multi-cycle divider: holds operands, stalls the pipe until the
// divider reports ready, writes HI/LO, and drains the divider after a flush.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_opa_i,
  input  logic [31:0] ex_opb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  div_ctl_state_e state_q, state_d;
  logic        cool_cnt_q, cool_cnt_d;
  logic        signed_q, signed_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        hilo_we_q, hilo_we_d;
  logic        annul_q, annul_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivCtlIdle;
      cool_cnt_q <= 1'b0;
      signed_q   <= 1'b0;
      opa_q      <= ZeroWord;
      opb_q      <= ZeroWord;
      hi_q       <= ZeroWord;
      lo_q       <= ZeroWord;
      hilo_we_q  <= 1'b0;
      annul_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      signed_q   <= signed_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      hilo_we_q  <= hilo_we_d;
      annul_q    <= annul_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    signed_d   = signed_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    hilo_we_d  = 1'b0;
    annul_d    = 1'b0;
    unique case (state_q)
      DivCtlIdle: begin
        if (ex_div_valid_i && !flush_i) begin
          signed_d = ex_signed_i;
          opa_d    = ex_opa_i;
          opb_d    = ex_opb_i;
          state_d  = DivCtlWait;
        end
      end
      DivCtlWait: begin
        // Flush wins over a same-cycle ready so a cancelled divide never reaches HI/LO.
        if (flush_i) begin
          state_d    = DivCtlCool;
          annul_d    = 1'b1;
          cool_cnt_d = 1'b0;
        end else if (div_ready_i == DivResultReady) begin
          state_d   = DivCtlDone;
          hi_d      = div_result_i[63:32];
          lo_d      = div_result_i[31:0];
          hilo_we_d = 1'b1;
        end
      end
      DivCtlDone: begin
        state_d = DivCtlIdle;
      end
      DivCtlCool: begin
        // Two cycles with start low lets the divider fall back to free before the next issue.
        if (cool_cnt_q) begin
          state_d    = DivCtlIdle;
          cool_cnt_d = 1'b0;
        end else begin
          cool_cnt_d = 1'b1;
        end
      end
      default: state_d = DivCtlIdle;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    div_start_o = DivStop;
    unique case (state_q)
      DivCtlIdle: stall_o = ex_div_valid_i & ~flush_i;
      DivCtlWait: begin
        stall_o     = 1'b1;
        div_start_o = DivStart;
      end
      DivCtlDone: stall_o = 1'b0;
      DivCtlCool: stall_o = ex_div_valid_i;
      default:    stall_o = 1'b0;
    endcase
  end

  assign div_annul_o   = annul_q;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = opa_q;
  assign div_opdata2_o = opb_q;
  assign hilo_we_o     = hilo_we_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider model (ready at t0+36, or t0+4 for /0).
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_div_valid_i;
  logic        ex_signed_i;
  logic [31:0] ex_opa_i;
  logic [31:0] ex_opb_i;
  logic        flush_i;
  logic        stall_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp = 0;
  int n_err = 0;

  div_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .ex_div_valid_i(ex_div_valid_i),
    .ex_signed_i   (ex_signed_i),
    .ex_opa_i      (ex_opa_i),
    .ex_opb_i      (ex_opb_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .div_start_o   (div_start_o),
    .div_annul_o   (div_annul_o),
    .div_signed_o  (div_signed_o),
    .div_opdata1_o (div_opdata1_o),
    .div_opdata2_o (div_opdata2_o),
    .div_result_i  (div_result_i),
    .div_ready_i   (div_ready_i),
    .hilo_we_o     (hilo_we_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: 0 free, 1 busy, 2 result held until start drops.
  logic [1:0] m_st;
  logic [5:0] m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st         <= 2'd0;
      m_cnt        <= 6'd0;
      div_ready_i  <= 1'b0;
      div_result_i <= 64'd0;
    end else begin
      case (m_st)
        2'd0: if (div_start_o && !div_annul_o) begin
          m_st  <= 2'd1;
          m_cnt <= (div_opdata2_o == 32'd0) ? 6'd1 : 6'd33;
        end
        2'd1: begin
          if (div_annul_o || !div_start_o) m_st <= 2'd0;
          else if (m_cnt == 6'd0) begin
            m_st         <= 2'd2;
            div_ready_i  <= 1'b1;
            div_result_i <= model_div(div_signed_o, div_opdata1_o, div_opdata2_o);
          end else m_cnt <= m_cnt - 6'd1;
        end
        2'd2: if (!div_start_o) begin
          m_st         <= 2'd0;
          div_ready_i  <= 1'b0;
          div_result_i <= 64'd0;
        end
        default: m_st <= 2'd0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issues one divide at cycle 0 and returns after the DONE cycle or after COOL ends.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, output int we_c, output int we_n,
                         output int annul_c, output int stall_n, output int start_first,
                         output int cool_start_n);
    int c;
    we_c = -1; we_n = 0; annul_c = -1; stall_n = 0; start_first = -1; cool_start_n = 0;
    @(negedge clk);
    ex_div_valid_i = 1'b1;
    ex_signed_i    = sgn;
    ex_opa_i       = a;
    ex_opb_i       = b;
    flush_i        = 1'b0;
    for (c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(negedge clk);
        flush_i = (c == flush_at);
        if (flush_i || annul_c >= 0) ex_div_valid_i = 1'b0;
      end
      #1;
      if (stall_o) stall_n++;
      if (div_start_o && start_first < 0) start_first = c;
      if (hilo_we_o) begin
        we_n++;
        if (we_c < 0) we_c = c;
      end
      if (div_annul_o && annul_c < 0) annul_c = c;
      if (annul_c >= 0 && div_start_o) cool_start_n++;
      if (we_c == c) break;
      if (annul_c >= 0 && c == annul_c + 1) break;
    end
    check_eq("no_timeout", {63'd0, (we_c < 0 && annul_c < 0)}, 64'd0);
    ex_div_valid_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  int we_c, we_n, annul_c, stall_n, start_first, cool_start_n;
  int found;

  initial begin
    rst = 1'b0; ex_div_valid_i = 1'b0; ex_signed_i = 1'b0;
    ex_opa_i = 32'd0; ex_opb_i = 32'd0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst_start", {63'd0, div_start_o}, 64'd0);
    check_eq("rst_we", {63'd0, hilo_we_o}, 64'd0);
    check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b1;

    // DIVU 100/7
    run_div(1'b0, 32'd100, 32'd7, -1, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("divu100_we_cycle", we_c, 37);
    check_eq("divu100_stall_cycles", stall_n, 37);
    check_eq("divu100_start_first", start_first, 1);
    check_eq("divu100_opb_held", div_opdata2_o, 32'd7);
    check_eq("divu100_hi", hi_o, 32'h0000_0002);
    check_eq("divu100_lo", lo_o, 32'h0000_000E);
    @(negedge clk); #1;
    check_eq("divu100_we_one_pulse", {63'd0, hilo_we_o}, 64'd0);
    check_eq("divu100_idle_no_stall", {63'd0, stall_o}, 64'd0);

    // DIV -7/2
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, we_c, we_n, annul_c, stall_n, start_first,
            cool_start_n);
    check_eq("div_neg_signed", {63'd0, div_signed_o}, 64'd1);
    check_eq("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", hi_o, 32'hFFFF_FFFF);

    // DIVU 5/0
    run_div(1'b0, 32'd5, 32'd0, -1, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("div0_we_cycle", we_c, 5);
    check_eq("div0_hilo", {hi_o, lo_o}, 64'd0);

    // DIV 100/7 flushed at t0+10, then DIVU 9/3
    run_div(1'b1, 32'd100, 32'd7, 10, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("flush10_annul_cycle", annul_c, 11);
    check_eq("flush10_no_we", we_n, 0);
    check_eq("flush10_stall_cycles", stall_n, 11);
    check_eq("flush10_start_low_cool", cool_start_n, 0);
    run_div(1'b0, 32'd9, 32'd3, -1, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("divu9_lo", lo_o, 32'd3);
    check_eq("divu9_hi", hi_o, 32'd0);

    // Flush coinciding with ready, then DIVU 20/6
    run_div(1'b0, 32'd100, 32'd7, 36, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("flush_rdy_no_we", we_n, 0);
    check_eq("flush_rdy_annul_cycle", annul_c, 37);
    check_eq("flush_rdy_lo_kept", lo_o, 32'd3);
    run_div(1'b0, 32'd20, 32'd6, -1, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("divu20_hilo", {hi_o, lo_o}, {32'd2, 32'd3});

    // Divide-by-zero flushed in WAIT, then back-to-back 10/3 and 10/4
    run_div(1'b0, 32'd5, 32'd0, 2, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("div0_flush_annul", annul_c, 3);
    check_eq("div0_flush_no_we", we_n, 0);
    run_div(1'b0, 32'd10, 32'd3, -1, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("b2b_first_we_cycle", we_c, 37);
    check_eq("b2b_first_hilo", {hi_o, lo_o}, {32'd1, 32'd3});
    run_div(1'b0, 32'd10, 32'd4, -1, we_c, we_n, annul_c, stall_n, start_first, cool_start_n);
    check_eq("b2b_second_we_cycle", we_c, 37);
    check_eq("b2b_second_hilo", {hi_o, lo_o}, {32'd2, 32'd2});

    // Flush at t0+2, new DIVU 9/3 presented during COOL
    @(negedge clk);
    ex_div_valid_i = 1'b1; ex_signed_i = 1'b1; ex_opa_i = 32'd100; ex_opb_i = 32'd7;
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1; ex_div_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0; ex_div_valid_i = 1'b1; ex_signed_i = 1'b0;
    ex_opa_i = 32'd9; ex_opb_i = 32'd3;
    #1;
    check_eq("cool1_annul", {63'd0, div_annul_o}, 64'd1);
    check_eq("cool1_stall_follows_valid", {63'd0, stall_o}, 64'd1);
    check_eq("cool1_start_low", {63'd0, div_start_o}, 64'd0);
    @(negedge clk); #1;
    check_eq("cool2_start_annul", {62'd0, div_start_o, div_annul_o}, 64'd0);
    @(negedge clk); #1;
    check_eq("cool_exit_idle_start", {63'd0, div_start_o}, 64'd0);
    @(negedge clk);
    ex_div_valid_i = 1'b0;
    #1;
    check_eq("reissue_start", {63'd0, div_start_o}, 64'd1);
    check_eq("reissue_opa", div_opdata1_o, 32'd9);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk); #1;
      if (hilo_we_o) found = 1;
    end
    check_eq("reissue_we_seen", found, 1);
    check_eq("reissue_hilo", {hi_o, lo_o}, {32'd0, 32'd3});

    // Asynchronous reset mid-WAIT
    @(negedge clk);
    ex_div_valid_i = 1'b1; ex_signed_i = 1'b1; ex_opa_i = 32'd10; ex_opb_i = 32'd3;
    @(negedge clk);
    ex_div_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre_rst_in_wait", {63'd0, div_start_o}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_stall_start", {62'd0, stall_o, div_start_o}, 64'd0);
    check_eq("arst_we_annul_sgn", {61'd0, hilo_we_o, div_annul_o, div_signed_o}, 64'd0);
    check_eq("arst_hilo", {hi_o, lo_o}, 64'd0);
    check_eq("arst_operands", {div_opdata1_o, div_opdata2_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check_eq("post_rst_idle", {62'd0, stall_o, div_start_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

EX-stage controller for the multi-cycle divider, sitting directly upstream of it. It accepts a DIV/DIVU from EX, holds the operands, and drives the divider's start/annul/signed inputs. It stalls the pipeline until the 64-bit result returns, then writes the quotient and remainder into the HI/LO write port. A pipeline flush during the operation cancels it cleanly.

## Interface
Parameters:
- none; all datapath widths are fixed at 32 bits per operand and 64 bits per result.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_div_valid_i  in  1  EX holds a DIV/DIVU this cycle.
- ex_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- ex_opa_i  in  32  dividend (rs).
- ex_opb_i  in  32  divisor (rt).
- flush_i  in  1  pipeline flush (exception/eret).
- stall_o  out  1  stall request to the pipeline control.
- div_start_o  out  1  to divider start_i; DivStart = 1, DivStop = 0.
- div_annul_o  out  1  to divider annul_i.
- div_signed_o  out  1  to divider signed_div_i.
- div_opdata1_o  out  32  to divider opdata1_i.
- div_opdata2_o  out  32  to divider opdata2_i.
- div_result_i  in  64  from divider; {remainder, quotient}.
- div_ready_i  in  1  from divider ready_o.
- hilo_we_o  out  1  HI/LO write enable, one-cycle pulse.
- hi_o  out  32  remainder for HI.
- lo_o  out  32  quotient for LO.

## Operation
States: IDLE, WAIT, DONE, COOL.

Outputs in each state:
- div_start_o = 1 only in WAIT.
- div_annul_o is a registered one-cycle pulse on entry to COOL.
- hilo_we_o is a registered one-cycle pulse on entry to DONE.

Transitions and stall behaviour:
- IDLE, ex_div_valid_i=1, flush_i=0: latch ex_signed_i, ex_opa_i and ex_opb_i into the div_* operand registers, then go to WAIT. stall_o=1 combinationally in this cycle.
- IDLE, flush_i=1: stay in IDLE; stall_o=0.
- WAIT:
  - stall_o=1.
  - Operands stay stable.
  - If flush_i=1, go to COOL. flush_i has priority over div_ready_i in the same cycle, and HI/LO are not written.
  - Else if div_ready_i=1, go to DONE. In the same edge, hi_o←div_result_i[63:32], lo_o←div_result_i[31:0] and hilo_we_o←1.
- DONE:
  - stall_o=0 so the held instruction retires.
  - ex_div_valid_i is ignored, because it is the same instruction.
  - Always go to IDLE.
- COOL:
  - Hold div_start_o=0 for exactly 2 cycles using a 1-bit counter. This lets the divider drain through DivByZero→DivEnd→DivFree, so a stale ready cannot satisfy the next operation.
  - stall_o = ex_div_valid_i.
  - Then go to IDLE.

Other rules:
- Divide-by-zero gets no special handling: the divider returns 0, and HI/LO are written with 0.
- hi_o and lo_o hold their values between writes.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and operand registers go to 0.
  - This applies mid-operation as well; the divider is reset by the same system reset.
- Issue cycle t0 → div_start_o=1 from t0+1.
- With the current divider:
  - Nonzero divisor: div_ready_i is first seen at t0+36, hilo_we_o=1 at t0+37 (DONE), and stall_o is asserted for t0..t0+36.
  - Zero divisor: div_ready_i at t0+4, hilo_we_o at t0+5.
- The controller must not rely on fixed latency and waits only on div_ready_i.
- div_start_o deasserts in the cycle after ready is seen, which returns the divider to DivFree.
- Back-to-back divides: the next issue is accepted in the IDLE cycle right after DONE, i.e. t0+38.
- Flush in WAIT:
  - Annul pulse at the next cycle.
  - Start is low for 2 cycles.
  - Earliest new issue in the cycle after COOL ends.

## Structure
- State encodings (DivCtlIdle, DivCtlWait, DivCtlDone, DivCtlCool) go in define.vh.
- The design reuses the existing define.vh constants DivStart, DivStop, DivResultReady and ZeroWord.
- Single flat module; no sub-module is warranted.
- The divider is instantiated beside it in the EX stage, not inside it.

## Test plan
- DIVU 100/7 → hilo_we_o one pulse, hi_o=0x00000002, lo_o=0x0000000E; stall_o high for 37 cycles.
- DIV -7/2 (0xFFFFFFF9/0x00000002) → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 5/0 → hi_o=lo_o=0, hilo_we_o at t0+5; no hang.
- DIV 100/7 with flush_i pulsed at t0+10 → div_annul_o pulse at t0+11, no hilo_we_o; a following DIVU 9/3 gives lo_o=3, hi_o=0.
- Flush in the same cycle as div_ready_i → no HI/LO write; next DIVU 20/6 gives lo_o=3, hi_o=2. Also covers a divide-by-zero flushed in WAIT, where COOL drains the stale ready.
- Back-to-back DIVU 10/3 then 10/4 → two pulses with (hi_o, lo_o) = (1, 3) then (2, 2). rst pulled low mid-WAIT → all outputs 0 immediately, state IDLE.
